// File: rtl/bullet_engine.sv
// ============================================================================
// Module   : bullet_engine
// Purpose  : single-bullet projectile engine (spawn, flight, wall/enemy impact,
//            re-fire cooldown, per-pixel bullet flag). Optional BULLET_SCORE_EN
//            adds a saturating enemy-hit score output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bullet_engine #(
    parameter int unsigned SPEED    = 4,
    parameter int unsigned B_SIZE   = 8,
    parameter int unsigned T_SIZE   = 32,
    parameter int unsigned X_MAX    = 639,
    parameter int unsigned Y_MAX    = 479,
    parameter int unsigned COOLDOWN = 15
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_clk,
    input  logic       is_shooting,
    input  logic [2:0] tank_dir,
    input  logic [9:0] tank_X,
    input  logic [9:0] tank_Y,
    input  logic [9:0] enemy_X,
    input  logic [9:0] enemy_Y,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    output logic [9:0] bullet_X,
    output logic [9:0] bullet_Y,
    output logic       bullet_active,
    output logic       is_bullet,
    output logic       hit,
    output logic       enemy_hit
`ifdef BULLET_SCORE_EN
    ,
    output logic [7:0] score
`endif
);

    localparam logic signed [10:0] SPD = 11'(SPEED);
    localparam logic signed [10:0] BSZ = 11'(B_SIZE);
    localparam logic signed [10:0] TSZ = 11'(T_SIZE);
    localparam logic signed [10:0] XM  = 11'(X_MAX);
    localparam logic signed [10:0] YM  = 11'(Y_MAX);
    localparam logic [10:0]        BU  = 11'(B_SIZE);
    localparam logic [10:0]        TU  = 11'(T_SIZE);
    localparam logic [10:0]        XU1 = 11'(X_MAX + 1);
    localparam logic [10:0]        YU1 = 11'(Y_MAX + 1);
    localparam logic [9:0]         B10 = 10'(B_SIZE);
    localparam logic [9:0]         T10 = 10'(T_SIZE);
    localparam logic [9:0]         OFF = 10'((T_SIZE - B_SIZE) / 2);
    localparam logic [7:0]         CD  = 8'(COOLDOWN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FLY  = 2'd1,
        COOL = 2'd2
    } state_t;

    state_t      state;
    logic        frame_d;
    logic        tick;
    logic        arm;
    logic [2:0]  dir;
    logic [7:0]  cnt;

    logic [10:0]        tx, ty;
    logic [9:0]         spawn_x, spawn_y;
    logic               spawn_off, dir_ok;
    logic signed [10:0] bx, by, ex, ey, nx, ny;
    logic               wall, enemy;

    always_comb begin
        tx        = {1'b0, tank_X};
        ty        = {1'b0, tank_Y};
        spawn_x   = tank_X + OFF;
        spawn_y   = tank_Y - B10;
        spawn_off = 1'b0;
        dir_ok    = 1'b1;
        case (tank_dir)
            3'd1: begin
                spawn_x   = tank_X + OFF;
                spawn_y   = tank_Y - B10;
                spawn_off = ty < BU;
            end
            3'd2: begin
                spawn_x   = tank_X + T10;
                spawn_y   = tank_Y + OFF;
                spawn_off = (tx + TU + BU) > XU1;
            end
            3'd3: begin
                spawn_x   = tank_X - B10;
                spawn_y   = tank_Y + OFF;
                spawn_off = tx < BU;
            end
            3'd4: begin
                spawn_x   = tank_X + OFF;
                spawn_y   = tank_Y + T10;
                spawn_off = (ty + TU + BU) > YU1;
            end
            default: dir_ok = 1'b0;
        endcase
    end

    // Next position is signed so an underflow reads as negative, not as a huge column.
    always_comb begin
        bx = signed'({1'b0, bullet_X});
        by = signed'({1'b0, bullet_Y});
        ex = signed'({1'b0, enemy_X});
        ey = signed'({1'b0, enemy_Y});
        nx = bx;
        ny = by;
        case (dir)
            3'd1:    ny = by - SPD;
            3'd2:    nx = bx + SPD;
            3'd3:    nx = bx - SPD;
            default: ny = by + SPD;
        endcase
        wall  = (nx < 11'sd0) | (ny < 11'sd0) |
                ((nx + BSZ - 11'sd1) > XM) | ((ny + BSZ - 11'sd1) > YM);
        enemy = (nx <= ex + TSZ - 11'sd1) & (nx + BSZ - 11'sd1 >= ex) &
                (ny <= ey + TSZ - 11'sd1) & (ny + BSZ - 11'sd1 >= ey);
    end

    assign is_bullet = bullet_active & ((DrawX - bullet_X) < B10) & ((DrawY - bullet_Y) < B10);

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state         <= IDLE;
            frame_d       <= 1'b0;
            tick          <= 1'b0;
            arm           <= 1'b1;
            dir           <= 3'd1;
            cnt           <= 8'd0;
            bullet_X      <= 10'd0;
            bullet_Y      <= 10'd0;
            bullet_active <= 1'b0;
            hit           <= 1'b0;
            enemy_hit     <= 1'b0;
        end else begin
            frame_d   <= frame_clk;
            tick      <= frame_clk & ~frame_d;
            hit       <= 1'b0;
            enemy_hit <= 1'b0;
            if (tick) begin
                if (!is_shooting) begin
                    arm <= 1'b1;
                end
                case (state)
                    IDLE: begin
                        if (is_shooting && arm && dir_ok) begin
                            dir <= tank_dir;
                            arm <= 1'b0;
                            if (spawn_off) begin
                                hit   <= 1'b1;
                                cnt   <= CD;
                                state <= COOL;
                            end else begin
                                bullet_X      <= spawn_x;
                                bullet_Y      <= spawn_y;
                                bullet_active <= 1'b1;
                                state         <= FLY;
                            end
                        end
                    end
                    FLY: begin
                        if (enemy || wall) begin
                            enemy_hit     <= enemy;
                            hit           <= ~enemy;
                            bullet_active <= 1'b0;
                            cnt           <= CD;
                            state         <= COOL;
                        end else begin
                            bullet_X <= nx[9:0];
                            bullet_Y <= ny[9:0];
                        end
                    end
                    COOL: begin
                        if (cnt <= 8'd1) begin
                            cnt   <= 8'd0;
                            state <= IDLE;
                        end else begin
                            cnt <= cnt - 8'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef BULLET_SCORE_EN
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            score <= 8'd0;
        end else if (enemy_hit && score != 8'hFF) begin
            score <= score + 8'd1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_bullet_engine.sv
// ============================================================================
// Module   : tb_bullet_engine
// Purpose  : self-checking bench for bullet_engine (vector table, directed
//            corner sequences, randomized frames against a reference model).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bullet_engine;

    localparam int B   = 8;
    localparam int T   = 32;
    localparam int SP  = 4;
    localparam int XM  = 639;
    localparam int YM  = 479;
    localparam int CD  = 15;
    localparam int OFF = (T - B) / 2;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       frame_clk = 1'b0;
    logic       is_shooting = 1'b0;
    logic [2:0] tank_dir = 3'd1;
    logic [9:0] tank_X = '0, tank_Y = '0, enemy_X = '0, enemy_Y = '0;
    logic [9:0] DrawX = '0, DrawY = '0;
    logic [9:0] bullet_X, bullet_Y;
    logic       bullet_active, is_bullet, hit, enemy_hit;
`ifdef BULLET_SCORE_EN
    logic [7:0] score;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    bit f_hit1, f_ehit1, f_hit2, f_ehit2;

    always #10 Clk = ~Clk;

    bullet_engine dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .is_shooting(is_shooting),
        .tank_dir(tank_dir), .tank_X(tank_X), .tank_Y(tank_Y),
        .enemy_X(enemy_X), .enemy_Y(enemy_Y), .DrawX(DrawX), .DrawY(DrawY),
        .bullet_X(bullet_X), .bullet_Y(bullet_Y), .bullet_active(bullet_active),
        .is_bullet(is_bullet), .hit(hit), .enemy_hit(enemy_hit)
`ifdef BULLET_SCORE_EN
        , .score(score)
`endif
    );

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One frame: raise frame_clk, sample both Clk cycles around the update.
    task automatic frame(input bit sh, input int d, input int tx, input int ty);
        @(negedge Clk);
        is_shooting = sh;
        tank_dir    = 3'(d);
        tank_X      = 10'(tx);
        tank_Y      = 10'(ty);
        frame_clk   = 1'b1;
        @(posedge Clk); @(posedge Clk); #1;
        f_hit1 = hit; f_ehit1 = enemy_hit;
        @(posedge Clk); #1;
        f_hit2 = hit; f_ehit2 = enemy_hit;
        @(negedge Clk);
        frame_clk = 1'b0;
        repeat (3) @(negedge Clk);
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset_n = 1'b0;
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
    endtask

    // Reference model, one call per frame tick.
    typedef enum {M_IDLE, M_FLY, M_COOL} mphase_t;
    mphase_t m_ph;
    int m_bx, m_by, m_dir, m_left, m_score;
    bit m_act, m_arm, m_hit, m_ehit;

    task automatic model_reset();
        m_ph = M_IDLE; m_bx = 0; m_by = 0; m_dir = 1; m_left = 0; m_score = 0;
        m_act = 0; m_arm = 1; m_hit = 0; m_ehit = 0;
    endtask

    task automatic model_tick(input bit sh, input int d, input int tx, input int ty,
                              input int ex, input int ey);
        int sx, sy, nx, ny;
        bit eh, wl;
        m_hit = 0; m_ehit = 0;
        case (m_ph)
            M_IDLE: if (sh && m_arm && d >= 1 && d <= 4) begin
                m_arm = 0; m_dir = d;
                sx = (d == 2) ? tx + T : (d == 3) ? tx - B : tx + OFF;
                sy = (d == 1) ? ty - B : (d == 4) ? ty + T : ty + OFF;
                if (sx < 0 || sy < 0 || sx + B > XM + 1 || sy + B > YM + 1) begin
                    m_hit = 1; m_left = CD; m_ph = M_COOL;
                end else begin
                    m_bx = sx; m_by = sy; m_act = 1; m_ph = M_FLY;
                end
            end
            M_FLY: begin
                nx = m_bx; ny = m_by;
                case (m_dir)
                    1: ny -= SP;
                    2: nx += SP;
                    3: nx -= SP;
                    default: ny += SP;
                endcase
                eh = nx <= ex + T - 1 && nx + B - 1 >= ex && ny <= ey + T - 1 && ny + B - 1 >= ey;
                wl = nx < 0 || ny < 0 || nx + B - 1 > XM || ny + B - 1 > YM;
                if (eh || wl) begin
                    m_ehit = eh; m_hit = !eh; m_act = 0; m_left = CD; m_ph = M_COOL;
                    if (eh && m_score < 255) m_score++;
                end else begin
                    m_bx = nx; m_by = ny;
                end
            end
            default: begin
                m_left--;
                if (m_left <= 0) m_ph = M_IDLE;
            end
        endcase
        if (!sh) m_arm = 1;
    endtask

    typedef struct {
        bit sh; int d; int tx; int ty;
        bit act; int bx; int by;
    } vec_t;
    vec_t vt[8];

    initial begin
        #2ms;
        $display("FAIL timeout: simulation did not finish, got 0 expected 1");
        $fatal(1, "timeout");
    end

    initial begin
        int ticks, spawns, px, py, ex, ey;
        bit prev, ib;

        repeat (3) @(negedge Clk);
        chk("reset_active", bullet_active, 0);
        chk("reset_x", bullet_X, 0);
        chk("reset_y", bullet_Y, 0);
        chk("reset_hit", hit, 0);
        chk("reset_ehit", enemy_hit, 0);
        chk("reset_isb", is_bullet, 0);
        Reset_n = 1'b1;

        // Invalid directions first, then an upward shot with a mid-flight direction change.
        vt[0] = '{1, 0, 500, 240, 0, 0, 0};
        vt[1] = '{1, 5, 500, 240, 0, 0, 0};
        vt[2] = '{1, 1, 500, 240, 1, 512, 232};
        vt[3] = '{0, 1, 500, 240, 1, 512, 228};
        vt[4] = '{0, 1, 500, 240, 1, 512, 224};
        vt[5] = '{0, 1, 500, 240, 1, 512, 220};
        vt[6] = '{1, 2, 500, 240, 1, 512, 216};
        vt[7] = '{0, 3, 500, 240, 1, 512, 212};
        enemy_X = 10'd0; enemy_Y = 10'd0;
        for (int i = 0; i < 8; i++) begin
            frame(vt[i].sh, vt[i].d, vt[i].tx, vt[i].ty);
            chk($sformatf("vec%0d_active", i), bullet_active, vt[i].act);
            chk($sformatf("vec%0d_x", i), bullet_X, vt[i].bx);
            chk($sformatf("vec%0d_y", i), bullet_Y, vt[i].by);
            chk($sformatf("vec%0d_hit", i), f_hit1 | f_ehit1, 0);
        end

        // Reset while in flight: bullet aborted, no pulse, engine back in IDLE.
        @(negedge Clk);
        Reset_n = 1'b0;
        @(posedge Clk); @(posedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;
        chk("midrst_active", bullet_active, 0);
        chk("midrst_x", bullet_X, 0);
        chk("midrst_y", bullet_Y, 0);
        chk("midrst_hit", hit, 0);
        @(posedge Clk); #1;
        chk("midrst_hit_after", hit | enemy_hit, 0);
        frame(1, 1, 500, 240);
        chk("midrst_refire_y", bullet_Y, 232);

        // Upward wall impact, then the cooldown window.
        do_reset();
        enemy_X = 10'd600; enemy_Y = 10'd440;
        frame(1, 1, 300, 40);
        chk("wall_spawn_y", bullet_Y, 32);
        chk("wall_spawn_x", bullet_X, 312);
        ticks = 0;
        for (int k = 1; k <= 9; k++) begin
            frame(0, 1, 300, 40);
            if (f_hit1) ticks = k;
            if (k == 8) chk("wall_y_at_0", bullet_Y, 0);
        end
        chk("wall_hit_tick", ticks, 9);
        chk("wall_hit_width", f_hit2, 0);
        chk("wall_ehit", f_ehit1, 0);
        chk("wall_active", bullet_active, 0);
        chk("wall_frozen_y", bullet_Y, 0);
        for (int c = 1; c <= 14; c++) frame(0, 1, 300, 40);
        frame(1, 1, 300, 40);
        chk("cool_reject15", bullet_active, 0);
        frame(1, 1, 300, 40);
        chk("cool_accept16", bullet_active, 1);
        chk("cool_accept16_y", bullet_Y, 32);

        // Rightward shot into the enemy.
        do_reset();
        enemy_X = 10'd200; enemy_Y = 10'd100;
        frame(1, 2, 100, 100);
        chk("enemy_spawn_x", bullet_X, 132);
        chk("enemy_spawn_y", bullet_Y, 112);
        ticks = 0;
        for (int k = 1; k <= 40 && ticks == 0; k++) begin
            frame(0, 2, 100, 100);
            if (f_ehit1) begin
                ticks = k;
                chk("enemy_no_wall", f_hit1, 0);
                chk("enemy_width", f_ehit2, 0);
            end
        end
        chk("enemy_tick", ticks, 16);
        chk("enemy_frozen_x", bullet_X, 192);
        chk("enemy_active", bullet_active, 0);
`ifdef BULLET_SCORE_EN
        chk("enemy_score", score, 1);
`endif

        // Holding Enter fires once; release then press fires again.
        do_reset();
        enemy_X = 10'd600; enemy_Y = 10'd440;
        spawns = 0; prev = 0;
        for (int k = 0; k < 80; k++) begin
            frame(1, 1, 300, 200);
            if (bullet_active && !prev) spawns++;
            prev = bullet_active;
        end
        chk("hold_spawns", spawns, 1);
        chk("hold_end_active", bullet_active, 0);
        frame(0, 1, 300, 200);
        frame(1, 1, 300, 200);
        chk("repress_active", bullet_active, 1);
        chk("repress_y", bullet_Y, 192);

        // Randomized frames against the reference model.
        do_reset();
        model_reset();
        ex = 300; ey = 200;
        for (int k = 0; k < 400; k++) begin
            bit sh;
            int d, tx, ty;
            if ($urandom_range(0, 15) == 0) begin
                ex = $urandom_range(0, 607); ey = $urandom_range(0, 447);
            end
            enemy_X = 10'(ex); enemy_Y = 10'(ey);
            sh = ($urandom_range(0, 9) < 3);
            d  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 7) : $urandom_range(1, 4);
            tx = $urandom_range(0, 607);
            ty = $urandom_range(0, 447);
            frame(sh, d, tx, ty);
            model_tick(sh, d, tx, ty, ex, ey);
            chk("rnd_active", bullet_active, m_act);
            chk("rnd_x", bullet_X, m_bx);
            chk("rnd_y", bullet_Y, m_by);
            chk("rnd_hit", f_hit1, m_hit);
            chk("rnd_ehit", f_ehit1, m_ehit);
            chk("rnd_pulse_end", f_hit2 | f_ehit2, 0);
`ifdef BULLET_SCORE_EN
            chk("rnd_score", score, m_score);
`endif
            for (int p = 0; p < 2; p++) begin
                px = m_bx + int'($urandom_range(0, 11)) - 2;
                py = m_by + int'($urandom_range(0, 11)) - 2;
                if (px < 0) px += 1024;
                if (py < 0) py += 1024;
                DrawX = 10'(px); DrawY = 10'(py);
                #1;
                ib = m_act && px >= m_bx && px <= m_bx + B - 1 && py >= m_by && py <= m_by + B - 1;
                chk("rnd_is_bullet", is_bullet, ib);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
